// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner/pointer encodings and default widths shared by the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_IF = 2'b01, OWN_D = 2'b10} owner_e;
  typedef enum logic {LAST_IF = 1'b0, LAST_D = 1'b1} last_e;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/arb2_rr.sv
// arb2_rr: two-input grant generator, fetch vs data
// MEM_ARB_RR_EN selects round-robin on conflicts; otherwise data always beats fetch
module arb2_rr
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic i_req_if,
  input  logic i_req_d,
  output logic o_gnt_if,
  output logic o_gnt_d
);
`ifdef MEM_ARB_RR_EN
  last_e r_last;
  logic  w_conflict;
  assign w_conflict = i_req_if & i_req_d;
  // pointer remembers the conflict winner and moves only when both requested
  always_ff @(posedge clk) begin
    if (rst) r_last <= LAST_IF;
    else if (w_conflict) r_last <= (r_last == LAST_IF) ? LAST_D : LAST_IF;
  end
  always_comb begin
    o_gnt_d  = i_req_d & (~i_req_if | (r_last == LAST_IF));
    o_gnt_if = i_req_if & ~o_gnt_d;
  end
`else
  always_comb begin
    o_gnt_d  = i_req_d;
    o_gnt_if = i_req_if & ~i_req_d;
  end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory between fetch and load/store ports
// Define MEM_ARB_RR_EN for round-robin conflict resolution (default: data over fetch)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);
  owner_e r_owner;
  owner_e w_owner_nxt;
  logic   w_if_req;
  logic   w_d_req;
  assign w_if_req = if_req & ~RESET;
  assign w_d_req  = d_req & ~RESET;
  arb2_rr u_arb (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .rst      (RESET),
`endif
    .i_req_if (w_if_req),
    .i_req_d  (w_d_req),
    .o_gnt_if (if_gnt),
    .o_gnt_d  (d_gnt)
  );
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    stall     = (w_if_req & ~if_gnt) | (w_d_req & ~d_gnt);
  end
  always_ff @(posedge clk) begin
    if (RESET) r_owner <= OWN_NONE;
    else r_owner <= w_owner_nxt;
  end
  // stores complete at grant, so only reads claim the returning data
  always_comb begin
    w_owner_nxt = if_gnt ? OWN_IF : (d_gnt & ~d_we) ? OWN_D : OWN_NONE;
  end
  // a read granted just before reset must not surface while RESET is high
  always_comb begin
    if_rvalid = ~RESET & (r_owner == OWN_IF);
    d_rvalid  = ~RESET & (r_owner == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_mem_port_arbiter;
  logic        clk = 0;
  logic        RESET = 1;
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  int n_checks = 0;
  int n_fail = 0;

  mem_port_arbiter dut (
    .clk(clk), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  // apply one cycle of inputs at the falling edge; outputs are then sampled 1ns later
  task automatic drive(input logic rst, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd, input logic [31:0] rd);
    @(negedge clk);
    RESET = rst; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; mem_rdata = rd;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 32'h20, 1, 0, 32'h24, 32'h1, 32'hFFFF_FFFF);
    drive(1, 1, 32'h20, 1, 1, 32'h24, 32'h1, 32'hFFFF_FFFF);
    n_checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we, stall} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 00000", {if_gnt, d_gnt, mem_en, mem_we, stall}); end
    n_checks++;
    if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 66'b0) begin n_fail++; $display("FAIL reset_resp got %b/%b %h/%h want all 0", if_rvalid, d_rvalid, if_rdata, d_rdata); end
    drive(0, 0, 0, 0, 0, 0, 0, 32'h1234);
    n_checks++;
    if ({if_rvalid, d_rvalid, stall, mem_en} !== 4'b0) begin n_fail++; $display("FAIL reset_idle got %b want 0000", {if_rvalid, d_rvalid, stall, mem_en}); end
  endtask

  task automatic test_fetch_only();
    drive(0, 1, 32'h10, 0, 0, 0, 0, 0);
    n_checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we, stall} !== 5'b10100) begin n_fail++; $display("FAIL fetch_gnt got %b want 10100", {if_gnt, d_gnt, mem_en, mem_we, stall}); end
    n_checks++;
    if (mem_addr !== 32'h10 || mem_wdata !== 0) begin n_fail++; $display("FAIL fetch_addr got %h/%h want 00000010/0", mem_addr, mem_wdata); end
    drive(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    n_checks++;
    if (if_rvalid !== 1 || if_rdata !== 32'hDEADBEEF || d_rvalid !== 0 || d_rdata !== 0) begin
      n_fail++; $display("FAIL fetch_resp got %b %h d %b %h want 1 deadbeef d 0 0", if_rvalid, if_rdata, d_rvalid, d_rdata);
    end
  endtask

  task automatic test_store_load();
    drive(0, 0, 0, 1, 1, 32'h4, 32'h55, 0);
    n_checks++;
    if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 32'h4 || mem_wdata !== 32'h55) begin
      n_fail++; $display("FAIL store got %b %h %h want 111 4 55", {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    drive(0, 0, 0, 1, 0, 32'h4, 32'h99, 32'h77);
    n_checks++;
    if ({d_gnt, mem_we, d_rvalid, if_rvalid} !== 4'b1000 || mem_wdata !== 32'h99) begin
      n_fail++; $display("FAIL load_issue got %b %h want 1000 99", {d_gnt, mem_we, d_rvalid, if_rvalid}, mem_wdata);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 32'h55);
    n_checks++;
    if (d_rvalid !== 1 || d_rdata !== 32'h55 || if_rvalid !== 0) begin n_fail++; $display("FAIL load_resp got %b %h if %b want 1 55 0", d_rvalid, d_rdata, if_rvalid); end
  endtask

  task automatic test_conflict();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h100 + i, 1, 0, 32'h200 + i, 0, 32'hA000 + i);
`ifdef MEM_ARB_RR_EN
      n_checks++;
      if ({d_gnt, if_gnt, stall} !== {(i % 2 == 0), (i % 2 == 1), 1'b1}) begin n_fail++; $display("FAIL rr_gnt%0d got %b", i, {d_gnt, if_gnt, stall}); end
      if (i > 0) begin
        n_checks++;
        if ({d_rvalid, if_rvalid} !== {(i % 2 == 1), (i % 2 == 0)} || (d_rdata | if_rdata) !== 32'hA000 + i) begin
          n_fail++; $display("FAIL rr_resp%0d got %b %h %h", i, {d_rvalid, if_rvalid}, d_rdata, if_rdata);
        end
      end
`else
      n_checks++;
      if ({d_gnt, if_gnt, stall} !== 3'b101 || mem_addr !== 32'h200 + i) begin n_fail++; $display("FAIL fixed_gnt%0d got %b %h want 101", i, {d_gnt, if_gnt, stall}, mem_addr); end
`endif
    end
`ifndef MEM_ARB_RR_EN
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0);
    n_checks++;
    if ({d_gnt, if_gnt, stall} !== 3'b010 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL fixed_release got %b %h want 010 100", {d_gnt, if_gnt, stall}, mem_addr); end
`endif
  endtask

  task automatic test_reset_mid_read();
    drive(0, 0, 0, 1, 0, 32'h8, 0, 0);
    n_checks++;
    if (d_gnt !== 1) begin n_fail++; $display("FAIL midrst_issue got %b want 1", d_gnt); end
    drive(1, 1, 32'h3, 1, 0, 32'h8, 0, 32'hCAFE);
    n_checks++;
    if ({d_rvalid, if_rvalid, if_gnt, d_gnt, mem_en, stall} !== 6'b0 || d_rdata !== 0 || mem_addr !== 0) begin
      n_fail++; $display("FAIL midrst_out got %b %h %h want 0", {d_rvalid, if_rvalid, if_gnt, d_gnt, mem_en, stall}, d_rdata, mem_addr);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 32'hCAFE);
    n_checks++;
    if ({d_rvalid, if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL midrst_owner got %b want 00", {d_rvalid, if_rvalid}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive(0, i < 4, i, 0, 0, 0, 0, 32'hB0 + i);
      if (i < 4) begin
        n_checks++;
        if (if_gnt !== 1 || stall !== 0 || mem_addr !== i) begin n_fail++; $display("FAIL b2b_gnt%0d got %b %b %h", i, if_gnt, stall, mem_addr); end
      end
      n_checks++;
      if (if_rvalid !== (i > 0) || if_rdata !== ((i > 0) ? 32'hB0 + i : 0)) begin n_fail++; $display("FAIL b2b_resp%0d got %b %h", i, if_rvalid, if_rdata); end
    end
  endtask

  // random traffic; the model tracks only which port expects data next cycle and who won the last conflict
  task automatic test_random();
    bit exp_if_v = 0, exp_d_v = 0, d_turn = 1;
    bit rst, ir, dr, dw, g_if, g_d;
    logic [31:0] ia, da, dd, rd, e_addr, e_wd;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 29) == 0);
      ir = $urandom_range(0, 1); dr = $urandom_range(0, 1); dw = $urandom_range(0, 1);
      ia = $urandom; da = $urandom; dd = $urandom; rd = $urandom;
      drive(rst, ir, ia, dr, dw, da, dd, rd);
      g_d = 0; g_if = 0;
      if (!rst) begin
`ifdef MEM_ARB_RR_EN
        if (ir && dr) begin g_d = d_turn; g_if = !d_turn; d_turn = !d_turn; end
        else begin g_d = dr; g_if = ir; end
`else
        g_d = dr; g_if = ir && !dr;
`endif
      end
      e_addr = g_d ? da : g_if ? ia : 0;
      e_wd = g_d ? dd : 0;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we, stall} !== {g_if, g_d, g_if | g_d, g_d & dw, !rst & ((ir & !g_if) | (dr & !g_d))}) begin
        n_fail++; $display("FAIL rnd_ctrl%0d got %b want %b", n, {if_gnt, d_gnt, mem_en, mem_we, stall},
                           {g_if, g_d, g_if | g_d, g_d & dw, !rst & ((ir & !g_if) | (dr & !g_d))});
      end
      n_checks++;
      if (mem_addr !== e_addr || mem_wdata !== e_wd) begin n_fail++; $display("FAIL rnd_bus%0d got %h %h want %h %h", n, mem_addr, mem_wdata, e_addr, e_wd); end
      n_checks++;
      if ({if_rvalid, d_rvalid} !== {exp_if_v & !rst, exp_d_v & !rst} || if_rdata !== ((exp_if_v && !rst) ? rd : 0) || d_rdata !== ((exp_d_v && !rst) ? rd : 0)) begin
        n_fail++; $display("FAIL rnd_resp%0d got %b %h %h want %b", n, {if_rvalid, d_rvalid}, if_rdata, d_rdata, {exp_if_v & !rst, exp_d_v & !rst});
      end
      exp_if_v = g_if;
      exp_d_v = g_d && !dw;
      if (rst) d_turn = 1;
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_store_load();
    test_conflict();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, synchronous-read instruction/data memory between the instruction-fetch path and the load/store path of the processor. Grants at most one access per cycle, steers address/write data to the memory, and routes the read data returned one cycle later to the requester that issued it. Drives a `stall` output that the program counter uses to hold its value while a fetch is not being granted.

## Interface
- `ADDR_W`, 32: word-address width.
- `DATA_W`, 32: data width.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch accepted this cycle (combinational).
- `if_rvalid`  out  1  `if_rdata` valid (registered, one cycle after `if_gnt`).
- `if_rdata`  out  DATA_W  fetched instruction.
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data access accepted this cycle (combinational).
- `d_rvalid`  out  1  `d_rdata` valid, one cycle after a granted load only.
- `d_rdata`  out  DATA_W  load data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory word address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en & ~mem_we`.
- `stall`  out  1  `(if_req & ~if_gnt) | (d_req & ~d_gnt)`.

## Operation
- Grant logic: exactly one of `if_gnt`, `d_gnt` is high when any request is present, and neither is high otherwise. A single requester is always granted immediately.
- Conflict (both requests high): resolved by the policy in Configuration.
- Memory steering: `mem_en = if_gnt | d_gnt`; `mem_we = d_gnt & d_we`; `mem_addr`/`mem_wdata` come from the granted requester. `mem_addr` and `mem_wdata` are 0 when there is no grant. `mem_wdata` is 0 on fetches.
- Response tracking: a registered owner FSM with states `OWN_NONE`, `OWN_IF` and `OWN_D`.
  - Next state is `OWN_IF` on `if_gnt`, `OWN_D` on `d_gnt & ~d_we`, and `OWN_NONE` otherwise (idle cycle or store).
  - `if_rvalid = (state == OWN_IF)` and `d_rvalid = (state == OWN_D)`.
  - Each `*_rdata` passes through `mem_rdata` while its rvalid is high, and is 0 otherwise.
- Stores complete at grant. No response is generated for a store.
- Back-to-back operation: a new grant may be issued in the same cycle that the previous response is delivered. Throughput is one access per cycle.

## Timing
- Grant to rvalid latency is exactly 1 cycle. Requests do not queue, and there is no internal buffering beyond the owner register.
- Reset (synchronous): owner = `OWN_NONE` and round-robin pointer = `LAST_IF`, so data wins the first conflict.
  - While `RESET` is high, all grants, `mem_en`, `mem_we` and `stall` are held at 0, and all rvalid/rdata outputs are 0.
- Reset mid-operation: a read granted in the cycle before `RESET` rises produces no rvalid. Requests are ignored while `RESET` is high.
- A requester that drops `req` before its grant is legal. Nothing is issued for it, and no state changes.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On conflict, the requester not granted at the last conflict wins, and the 1-bit pointer updates only on conflict cycles.
- `MEM_ARB_RR_EN` undefined: fixed priority, data over fetch. The pointer register is not built. Fetch can be starved by continuous data requests; this is acceptable because the control logic never issues data requests on consecutive cycles.

## Structure
- Shared package `mem_arb_pkg`:
  - owner state encoding (`OWN_NONE`=2'b00, `OWN_IF`=2'b01, `OWN_D`=2'b10);
  - pointer encoding (`LAST_IF`=1'b0, `LAST_D`=1'b1);
  - default `ADDR_W`/`DATA_W`.
- One sub-module, `arb2_rr`, is natural: a two-input grant generator with an optional round-robin pointer under `MEM_ARB_RR_EN`. Steering and owner tracking stay in the top level.

## Test plan
- Fetch only. Stimulus: `if_req`=1 with `if_addr`=0x10 and `mem_rdata`=0xDEADBEEF next cycle. Required: `if_gnt`=1 and `mem_en`=1 with `mem_addr`=0x10 in the same cycle; next cycle `if_rvalid`=1 and `if_rdata`=0xDEADBEEF, with `d_rvalid`=0.
- Store then load. Stimulus: `d_we`=1 with `d_addr`=0x4 and `d_wdata`=0x55, then a load from 0x4. Required: store cycle `mem_we`=1, `mem_wdata`=0x55, and no rvalid after it; load cycle followed by `d_rvalid`=1 with `d_rdata` equal to the returned data.
- Conflict, fixed priority (macro undefined). Stimulus: both requests held for 2 cycles. Required: `d_gnt`=1 and `stall`=1 both cycles, with `if_gnt`=0; `if_gnt`=1 in the cycle after `d_req` drops.
- Conflict, round robin (macro defined). Stimulus: both requests held continuously from reset. Required: grants alternate D, IF, D, IF; each rvalid lands on the correct port one cycle after its grant.
- Reset mid-read. Stimulus: load granted, then `RESET`=1 in the next cycle. Required: `d_rvalid`=0 during reset, all outputs 0, and owner back at `OWN_NONE`.
- Back-to-back fetches. Stimulus: `if_req` held for 4 cycles with addresses 0..3. Required: 4 consecutive grants, `if_rvalid` high for cycles 1 to 4, and `stall`=0 throughout.
